// File: rtl/rf_bus_slave.sv
// rf_bus_slave: memory-mapped register file behind the UART2BUS bus master.
//
// Request/grant handshake: the master raises int_req and holds it. After
// GNT_DELAY cycles int_gnt rises (registered). int_gnt stays high until the
// master drops int_req. Accesses (int_write / int_read, one location per
// cycle) are accepted only on cycles where int_gnt=1. A read that is accepted
// shows up RD_LAT cycles later as a one-cycle int_rd_valid strobe with its
// data on int_rd_data. After int_req drops, the slave waits until all reads
// in flight have been delivered before it considers a new request.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   int_req       bus request from the master
//   int_gnt       bus grant to the master
//   int_address   access address (range-checked against DEPTH)
//   int_wr_data   write data
//   int_write     write strobe
//   int_read      read strobe
//   int_rd_data   read data, valid while int_rd_valid=1, held otherwise
//   int_rd_valid  read data strobe
//   int_err       one-cycle pulse for a rejected access
//   access_count  accepted accesses, wraps modulo 2**16
//   dbg_state     current grant FSM state (IDLE=0, WAIT=1, GRANT=2, DRAIN=3)

module rf_bus_slave #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 1,
  parameter int GNT_DELAY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              int_req,
  output logic              int_gnt,
  input  logic [ADDR_W-1:0] int_address,
  input  logic [DATA_W-1:0] int_wr_data,
  input  logic              int_write,
  input  logic              int_read,
  output logic [DATA_W-1:0] int_rd_data,
  output logic              int_rd_valid,
  output logic              int_err,
  output logic [15:0]       access_count,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Value of the wait counter on the last WAIT cycle before GRANT.
  localparam logic [3:0] GNT_LAST = 4'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] v_pipe;
  logic [DATA_W-1:0] d_pipe [RD_LAT];

  logic              pipe_busy;
  logic              in_range;
  logic              wr_ok;
  logic              rd_acc;
  logic              rd_ok;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign in_range = 32'(int_address) < DEPTH;
  assign idx      = int_address[IDX_W-1:0];
  assign wr_ok    = int_gnt & int_write & ~int_read & in_range;
  // Any granted single read enters the pipeline, even out of range, so the
  // master always gets a strobe back and never stalls waiting for data.
  assign rd_acc   = int_gnt & int_read & ~int_write;
  assign rd_ok    = rd_acc & in_range;
  assign acc_err  = (int_write | int_read) &
                    (~int_gnt | (int_write & int_read) | ~in_range);
  assign rd_word  = rd_ok ? mem[idx] : '0;

  assign pipe_busy = |v_pipe;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (int_req) begin
          cnt_nx = '0;
          if (GNT_DELAY == 0) state_nx = GRANT;
          else                state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!int_req)               state_nx = IDLE;
        else if (cnt == GNT_LAST)   state_nx = GRANT;
        else                        cnt_nx   = cnt + 4'd1;
      end
      GRANT: begin
        if (!int_req) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      int_gnt <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      // Grant is registered off the next state so it tracks GRANT exactly.
      int_gnt <= (state_nx == GRANT);
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[idx] <= int_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: data stages only load when a valid beat arrives, so the
  // last stage (the output) holds its value between strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) d_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= rd_acc;
      if (rd_acc) d_pipe[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign int_rd_valid = v_pipe[RD_LAT-1];
  assign int_rd_data  = d_pipe[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Error pulse and access counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      int_err      <= 1'b0;
      access_count <= '0;
    end else begin
      int_err <= acc_err;
      if (wr_ok | rd_ok) access_count <= access_count + 16'd1;
    end
  end

endmodule

// File: doc/rf_bus_slave.md
Name: rf_bus_slave

Overview:
- Parametrised, synthesizable successor of the register-file bus model. It serves as the memory-mapped register file behind the UART2BUS DUT's non-standard interface.
- Owns the grant handshake: int_req in, int_gnt out, with a programmable grant delay.
- Adds a configurable read pipeline latency (int_rd_valid strobe), address range checking, illegal-access detection and an access counter for scoreboarding.

Parameters:
- ADDR_W, 16, width of int_address
- DATA_W, 8, width of int_wr_data / int_rd_data
- DEPTH, 256, number of implemented locations (1 .. 2**ADDR_W)
- RD_LAT, 1, read latency in cycles, legal range 1..4
- GNT_DELAY, 2, cycles from sampled int_req to int_gnt assertion, legal range 0..15

Ports:
- clock  in  1  global clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- int_req  in  1  bus request from DUT
- int_gnt  out  1  bus grant to DUT
- int_address  in  ADDR_W  access address
- int_wr_data  in  DATA_W  write data
- int_write  in  1  write strobe, one location per cycle
- int_read  in  1  read strobe, one location per cycle
- int_rd_data  out  DATA_W  read data, valid while int_rd_valid=1
- int_rd_valid  out  1  read data strobe
- int_err  out  1  one-cycle error pulse
- access_count  out  16  number of accepted accesses, wraps at 65535->0

Behaviour:
- Reset (reset=0, asynchronous):
  - int_gnt=0, int_rd_data=0, int_rd_valid=0, int_err=0, access_count=0.
  - All DEPTH locations cleared to 0; read pipeline flushed; FSM forced to IDLE.
  - Reset asserted mid-burst aborts everything immediately. No late int_rd_valid appears after release.
- FSM states IDLE, WAIT, GRANT, DRAIN:
  - IDLE: int_req=1 -> WAIT with delay counter=0. If GNT_DELAY=0, go directly to GRANT, so int_gnt rises on the cycle after int_req is sampled.
  - WAIT: counter increments every cycle. When counter==GNT_DELAY-1 -> GRANT. int_req=0 -> IDLE, no grant issued.
  - GRANT: int_gnt=1 (registered). int_req=0 -> DRAIN, with int_gnt=0 from that edge.
  - DRAIN: int_gnt=0. Wait until the read pipeline is empty, then -> IDLE. A new int_req is not considered until IDLE.
- Access acceptance (only on cycles where int_gnt=1):
  - write=1, read=0, address<DEPTH: mem[address] <= int_wr_data at this edge; access_count++.
  - read=1, write=0, address<DEPTH: mem[address] enters the pipeline and appears on int_rd_data with int_rd_valid=1 exactly RD_LAT cycles later; access_count++.
  - Back-to-back reads every cycle are supported at full throughput.
  - A write then a read of the same address on the next cycle returns the new data.
- Errors: int_err pulses for one cycle, the access has no effect, access_count is unchanged.
  - write=1 and read=1 on the same cycle.
  - address>=DEPTH: a read still produces int_rd_valid after RD_LAT with int_rd_data=0, so the DUT never hangs.
  - write or read asserted while int_gnt=0.
- Burst address continuation belongs to the DUT. The block applies no wrap. Addresses are taken as presented, and range is checked per access.
- int_rd_data holds its last value when int_rd_valid=0.
- access_count increments modulo 2**16.

Test Plan:
- GNT_DELAY=2: raise int_req at cycle 0 -> int_gnt=1 from cycle 3. Drop int_req at cycle 10 -> int_gnt=0 at cycle 11, FSM back in IDLE at cycle 12.
- Under grant, write 0xA5 to 0x0010, then read 0x0010 on the next cycle with RD_LAT=2 -> int_rd_valid=1 with int_rd_data=0xA5 two cycles after the read. access_count goes 0->1->2.
- Burst: write 0x01..0x04 to 0x00FC..0x00FF, then a 4-cycle back-to-back read -> four consecutive int_rd_valid cycles returning 0x01, 0x02, 0x03, 0x04.
- DEPTH=256: write to 0x0100 -> int_err pulse and access_count unchanged. Read of 0x0100 -> int_rd_valid with data 0x00 and an int_err pulse. Simultaneous read+write -> int_err, mem unchanged.
- Access without grant: int_write=1 with int_gnt=0 -> int_err pulse, mem unchanged. int_req dropped during WAIT -> int_gnt never asserts.
- Reset mid-read: issue a read with RD_LAT=3, assert reset after 1 cycle -> no int_rd_valid afterwards. After release, all outputs=0 and the previously written 0xA5 at 0x0010 reads back 0x00.
